// File: rtl/mano_mem_arbiter_pkg.sv
// Shared definitions for the Mano main-memory arbiter: default widths,
// FSM state encoding and read-return owner tags.
package mano_mem_arbiter_pkg;

    localparam int AW_DEF = 12;
    localparam int DW_DEF = 16;
    localparam int CNT_W  = 4;

    typedef enum logic {
        ST_ARB  = 1'b0,
        ST_LOCK = 1'b1
    } arb_state_t;

    typedef enum logic {
        OWN_CORE = 1'b0,
        OWN_LD   = 1'b1
    } owner_t;

endpackage

// File: rtl/mano_mem_arbiter_if.sv
// Bus bundle between the core, the loader, the memory macro and the arbiter.
// The slave modport is the arbiter's view; the master modport is everything around it.
interface mano_mem_arbiter_if
    import mano_mem_arbiter_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF
) ();

    // Requests are levels held until the matching *_gnt is seen high in the same
    // cycle; *_rvalid pulses exactly one cycle after a read grant, with *_rdata.
    logic          core_rd;
    logic          core_wr;
    logic [AW-1:0] core_addr;
    logic [DW-1:0] core_wdata;
    logic          core_gnt;
    logic          core_rvalid;
    logic [DW-1:0] core_rdata;

    logic          ld_rd;
    logic          ld_wr;
    logic          ld_lock;
    logic [AW-1:0] ld_addr;
    logic [DW-1:0] ld_wdata;
    logic          ld_gnt;
    logic          ld_rvalid;
    logic [DW-1:0] ld_rdata;
    logic          locked;

    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    arb_state_t       dbg_state;
    logic [CNT_W-1:0] dbg_wait_cnt;

    modport slave (
        input  core_rd, core_wr, core_addr, core_wdata,
        output core_gnt, core_rvalid, core_rdata,
        input  ld_rd, ld_wr, ld_lock, ld_addr, ld_wdata,
        output ld_gnt, ld_rvalid, ld_rdata, locked,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata,
        output dbg_state, dbg_wait_cnt
    );

    modport master (
        output core_rd, core_wr, core_addr, core_wdata,
        input  core_gnt, core_rvalid, core_rdata,
        output ld_rd, ld_wr, ld_lock, ld_addr, ld_wdata,
        input  ld_gnt, ld_rvalid, ld_rdata, locked,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata,
        input  dbg_state, dbg_wait_cnt
    );

endinterface

// File: rtl/mano_arb_starve_cnt.sv
// Saturating count of consecutive cycles the loader was denied; at-limit
// forces the next arbitration in the loader's favour.
module mano_arb_starve_cnt
    import mano_mem_arbiter_pkg::*;
#(
    parameter int LIM = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_clr,
    input  logic             i_inc,
    output logic [CNT_W-1:0] o_cnt,
    output logic             o_at_lim
);

    localparam logic [CNT_W-1:0] LIM_V = CNT_W'(LIM);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) begin
            r_cnt <= '0;
        end else if (i_inc && (r_cnt != LIM_V)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_cnt    = r_cnt;
    assign o_at_lim = (r_cnt == LIM_V);

endmodule

// File: rtl/mano_mem_arbiter.sv
// Single-port memory arbiter between the Mano core and a loader/debug master,
// with core priority, loader starvation protection and a loader lock mode.
module mano_mem_arbiter
    import mano_mem_arbiter_pkg::*;
#(
    parameter int AW         = AW_DEF,
    parameter int DW         = DW_DEF,
    parameter int STARVE_LIM = 4
) (
    input  logic mclk,
    input  logic mrst,
    mano_mem_arbiter_if.slave bus
);

    logic             w_core_req;
    logic             w_ld_req;
    logic             w_exclusive;
    logic             w_at_lim;
    logic             w_core_gnt;
    logic             w_ld_gnt;
    logic             w_mem_en;
    logic             w_mem_we;
    logic [AW-1:0]    w_mem_addr;
    logic [DW-1:0]    w_mem_wdata;
    logic             w_core_ret;
    logic             w_ld_ret;
    logic [CNT_W-1:0] w_wait_cnt;

    arb_state_t    r_state;
    logic          r_pend;
    owner_t        r_tag;
    logic [DW-1:0] r_core_rdata;
    logic [DW-1:0] r_ld_rdata;

    assign w_core_req  = bus.core_rd | bus.core_wr;
    assign w_ld_req    = bus.ld_rd | bus.ld_wr;
    // The cycle ld_lock drops is already arbitrated normally.
    assign w_exclusive = (r_state == ST_LOCK) && bus.ld_lock;

    always_comb begin
        w_core_gnt = 1'b0;
        w_ld_gnt   = 1'b0;
        if (!mrst) begin
            if (w_exclusive) begin
                w_ld_gnt = w_ld_req;
            end else begin
                w_ld_gnt   = w_ld_req && (!w_core_req || w_at_lim);
                w_core_gnt = w_core_req && !w_ld_gnt;
            end
        end
    end

    mano_arb_starve_cnt #(
        .LIM (STARVE_LIM)
    ) u_starve_cnt (
        .i_clk    (mclk),
        .i_rst    (mrst),
        .i_clr    (!w_ld_req || w_ld_gnt),
        .i_inc    (w_ld_req && !w_ld_gnt),
        .o_cnt    (w_wait_cnt),
        .o_at_lim (w_at_lim)
    );

    // Write wins over read when a port raises both strobes.
    assign w_mem_en    = w_core_gnt | w_ld_gnt;
    assign w_mem_we    = w_ld_gnt ? bus.ld_wr : (w_core_gnt & bus.core_wr);
    assign w_mem_addr  = w_ld_gnt ? bus.ld_addr : bus.core_addr;
    assign w_mem_wdata = w_ld_gnt ? bus.ld_wdata : bus.core_wdata;

    always_ff @(posedge mclk) begin
        if (mrst) begin
            r_state      <= ST_ARB;
            r_pend       <= 1'b0;
            r_tag        <= OWN_CORE;
            r_core_rdata <= '0;
            r_ld_rdata   <= '0;
        end else begin
            case (r_state)
                ST_ARB:  if (w_ld_gnt && bus.ld_lock) r_state <= ST_LOCK;
                ST_LOCK: if (!bus.ld_lock) r_state <= ST_ARB;
                default: r_state <= ST_ARB;
            endcase
            r_pend <= w_mem_en && !w_mem_we;
            r_tag  <= w_ld_gnt ? OWN_LD : OWN_CORE;
            if (w_core_ret) r_core_rdata <= bus.mem_rdata;
            if (w_ld_ret)   r_ld_rdata   <= bus.mem_rdata;
        end
    end

    // A reset landing on the return cycle swallows the response.
    assign w_core_ret = r_pend && !mrst && (r_tag == OWN_CORE);
    assign w_ld_ret   = r_pend && !mrst && (r_tag == OWN_LD);

    assign bus.core_gnt    = w_core_gnt;
    assign bus.core_rvalid = w_core_ret;
    assign bus.core_rdata  = w_core_ret ? bus.mem_rdata : r_core_rdata;
    assign bus.ld_gnt      = w_ld_gnt;
    assign bus.ld_rvalid   = w_ld_ret;
    assign bus.ld_rdata    = w_ld_ret ? bus.mem_rdata : r_ld_rdata;
    assign bus.locked      = (r_state == ST_LOCK);

    assign bus.mem_en    = w_mem_en;
    assign bus.mem_we    = w_mem_we;
    assign bus.mem_addr  = w_mem_addr;
    assign bus.mem_wdata = w_mem_wdata;

    assign bus.dbg_state    = r_state;
    assign bus.dbg_wait_cnt = w_wait_cnt;

endmodule

// File: tb/tb_mano_mem_arbiter.sv
// Self-checking bench for mano_mem_arbiter: directed scenarios followed by a
// randomized run against a rule-level reference model and a read scoreboard.
module tb_mano_mem_arbiter;
    import mano_mem_arbiter_pkg::*;

    localparam int AW  = 12;
    localparam int DW  = 16;
    localparam int LIM = 4;

    logic mclk = 1'b0;
    logic mrst;

    int checks = 0;
    int errors = 0;

    mano_mem_arbiter_if #(.AW(AW), .DW(DW)) bus ();

    mano_mem_arbiter #(.AW(AW), .DW(DW), .STARVE_LIM(LIM)) dut (
        .mclk (mclk),
        .mrst (mrst),
        .bus  (bus)
    );

    always #5 mclk = ~mclk;

    logic [DW-1:0] mem     [0:4095];
    logic [DW-1:0] ref_mem [0:4095];

    always @(posedge mclk) begin
        if (bus.mem_en) begin
            if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
            else            bus.mem_rdata     <= mem[bus.mem_addr];
        end
    end

    task automatic tick();
        @(posedge mclk);
        #1;
    endtask

    task automatic drive_idle();
        bus.core_rd = 0; bus.core_wr = 0; bus.core_addr = '0; bus.core_wdata = '0;
        bus.ld_rd = 0; bus.ld_wr = 0; bus.ld_lock = 0; bus.ld_addr = '0; bus.ld_wdata = '0;
    endtask

    task automatic test_reset();
        mrst = 1;
        drive_idle();
        tick();
        tick();
        mrst = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge mclk);
            checks++;
            if ({bus.core_gnt, bus.core_rvalid, bus.ld_gnt, bus.ld_rvalid, bus.locked, bus.mem_en, bus.mem_we} !== 7'b0) begin
                errors++;
                $display("FAIL reset_flags cyc=%0d got=%b exp=0", i,
                         {bus.core_gnt, bus.core_rvalid, bus.ld_gnt, bus.ld_rvalid, bus.locked, bus.mem_en, bus.mem_we});
            end
            checks++;
            if (bus.core_rdata !== 16'h0 || bus.ld_rdata !== 16'h0 || bus.mem_addr !== 12'h0 || bus.mem_wdata !== 16'h0) begin
                errors++;
                $display("FAIL reset_data cyc=%0d core_rdata=%h ld_rdata=%h addr=%h wdata=%h exp=0",
                         i, bus.core_rdata, bus.ld_rdata, bus.mem_addr, bus.mem_wdata);
            end
            checks++;
            if (bus.dbg_state !== ST_ARB || bus.dbg_wait_cnt !== 4'd0) begin
                errors++;
                $display("FAIL reset_state cyc=%0d state=%0d wait=%0d exp=ARB/0", i, bus.dbg_state, bus.dbg_wait_cnt);
            end
            tick();
        end
    endtask

    task automatic test_core_read();
        mem[12'h010] = 16'hBEEF;
        bus.core_rd = 1; bus.core_addr = 12'h010;
        @(negedge mclk);
        checks++;
        if (bus.core_gnt !== 1'b1 || bus.ld_gnt !== 1'b0 || bus.mem_en !== 1'b1 || bus.mem_we !== 1'b0 || bus.mem_addr !== 12'h010) begin
            errors++;
            $display("FAIL core_read_grant gnt=%b ld_gnt=%b en=%b we=%b addr=%h exp=1/0/1/0/010",
                     bus.core_gnt, bus.ld_gnt, bus.mem_en, bus.mem_we, bus.mem_addr);
        end
        tick();
        drive_idle();
        @(negedge mclk);
        checks++;
        if (bus.core_rvalid !== 1'b1 || bus.core_rdata !== 16'hBEEF || bus.ld_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL core_read_data rvalid=%b rdata=%h ld_rvalid=%b exp=1/beef/0",
                     bus.core_rvalid, bus.core_rdata, bus.ld_rvalid);
        end
        tick();
        @(negedge mclk);
        checks++;
        if (bus.core_rvalid !== 1'b0 || bus.core_rdata !== 16'hBEEF) begin
            errors++;
            $display("FAIL core_read_hold rvalid=%b rdata=%h exp=0/beef", bus.core_rvalid, bus.core_rdata);
        end
        tick();
    endtask

    task automatic test_contention();
        logic exp_ld;
        bus.core_rd = 1; bus.core_addr = 12'h020;
        bus.ld_rd = 1;   bus.ld_addr = 12'h030;
        for (int i = 0; i < 10; i++) begin
            exp_ld = ((i % (LIM + 1)) == LIM);
            @(negedge mclk);
            checks++;
            if (bus.ld_gnt !== exp_ld || bus.core_gnt !== !exp_ld) begin
                errors++;
                $display("FAIL contention cyc=%0d core_gnt=%b ld_gnt=%b exp_ld=%b", i, bus.core_gnt, bus.ld_gnt, exp_ld);
            end
            checks++;
            if (bus.dbg_wait_cnt !== 4'(i % (LIM + 1))) begin
                errors++;
                $display("FAIL contention_wait cyc=%0d got=%0d exp=%0d", i, bus.dbg_wait_cnt, i % (LIM + 1));
            end
            tick();
        end
        drive_idle();
        tick();
        tick();
    endtask

    task automatic test_lock_burst();
        for (int i = 0; i < 6; i++) begin
            drive_idle();
            if (i < 4) begin
                bus.ld_wr = 1; bus.ld_lock = 1;
                bus.ld_addr = 12'h100 + 12'(i); bus.ld_wdata = 16'hA000 + 16'(i);
            end
            if (i >= 1 && i <= 4) begin
                bus.core_rd = 1; bus.core_addr = 12'h040;
            end
            @(negedge mclk);
            checks++;
            if (bus.locked !== ((i >= 1) && (i <= 4))) begin
                errors++;
                $display("FAIL lock_locked cyc=%0d got=%b exp=%b", i, bus.locked, (i >= 1) && (i <= 4));
            end
            if (i < 4) begin
                checks++;
                if (bus.ld_gnt !== 1'b1 || bus.core_gnt !== 1'b0 || bus.mem_we !== 1'b1) begin
                    errors++;
                    $display("FAIL lock_burst cyc=%0d ld_gnt=%b core_gnt=%b we=%b exp=1/0/1", i, bus.ld_gnt, bus.core_gnt, bus.mem_we);
                end
            end else if (i == 4) begin
                checks++;
                if (bus.core_gnt !== 1'b1 || bus.ld_gnt !== 1'b0) begin
                    errors++;
                    $display("FAIL lock_release core_gnt=%b ld_gnt=%b exp=1/0", bus.core_gnt, bus.ld_gnt);
                end
            end
            tick();
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (mem[12'h100 + 12'(i)] !== 16'hA000 + 16'(i)) begin
                errors++;
                $display("FAIL lock_write addr=%h got=%h exp=%h", 12'h100 + 12'(i), mem[12'h100 + 12'(i)], 16'hA000 + 16'(i));
            end
        end
    endtask

    task automatic test_interleaved();
        mem[12'h050] = 16'h5A5A;
        mem[12'h060] = 16'h0F0F;
        drive_idle();
        bus.ld_rd = 1; bus.ld_addr = 12'h050;
        tick();
        drive_idle();
        bus.core_rd = 1; bus.core_addr = 12'h060;
        @(negedge mclk);
        checks++;
        if (bus.ld_rvalid !== 1'b1 || bus.ld_rdata !== 16'h5A5A || bus.core_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL interleave_ld ld_rvalid=%b ld_rdata=%h core_rvalid=%b exp=1/5a5a/0",
                     bus.ld_rvalid, bus.ld_rdata, bus.core_rvalid);
        end
        tick();
        drive_idle();
        @(negedge mclk);
        checks++;
        if (bus.core_rvalid !== 1'b1 || bus.core_rdata !== 16'h0F0F || bus.ld_rvalid !== 1'b0 || bus.ld_rdata !== 16'h5A5A) begin
            errors++;
            $display("FAIL interleave_core core_rvalid=%b core_rdata=%h ld_rvalid=%b ld_rdata=%h exp=1/0f0f/0/5a5a",
                     bus.core_rvalid, bus.core_rdata, bus.ld_rvalid, bus.ld_rdata);
        end
        tick();
    endtask

    task automatic test_rd_wr_both();
        drive_idle();
        bus.core_rd = 1; bus.core_wr = 1; bus.core_addr = 12'h070; bus.core_wdata = 16'h1234;
        @(negedge mclk);
        checks++;
        if (bus.core_gnt !== 1'b1 || bus.mem_we !== 1'b1 || bus.mem_wdata !== 16'h1234) begin
            errors++;
            $display("FAIL rdwr_grant gnt=%b we=%b wdata=%h exp=1/1/1234", bus.core_gnt, bus.mem_we, bus.mem_wdata);
        end
        tick();
        drive_idle();
        @(negedge mclk);
        checks++;
        if (bus.core_rvalid !== 1'b0 || mem[12'h070] !== 16'h1234) begin
            errors++;
            $display("FAIL rdwr_result rvalid=%b mem=%h exp=0/1234", bus.core_rvalid, mem[12'h070]);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        drive_idle();
        bus.core_rd = 1; bus.core_addr = 12'h010;
        bus.ld_rd = 1;   bus.ld_addr = 12'h011;
        @(negedge mclk);
        checks++;
        if (bus.core_gnt !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_grant got=%b exp=1", bus.core_gnt);
        end
        tick();
        drive_idle();
        mrst = 1;
        @(negedge mclk);
        checks++;
        if (bus.core_rvalid !== 1'b0 || bus.ld_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_rvalid core=%b ld=%b exp=0/0", bus.core_rvalid, bus.ld_rvalid);
        end
        tick();
        mrst = 0;
        @(negedge mclk);
        checks++;
        if (bus.core_rvalid !== 1'b0 || bus.dbg_state !== ST_ARB || bus.dbg_wait_cnt !== 4'd0 || bus.locked !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_after rvalid=%b state=%0d wait=%0d locked=%b exp=0/ARB/0/0",
                     bus.core_rvalid, bus.dbg_state, bus.dbg_wait_cnt, bus.locked);
        end
        tick();
    endtask

    // Reference model: core priority, loader wins after LIM denied cycles,
    // exclusive loader ownership while locked and ld_lock stays high.
    task automatic test_random();
        logic [DW:0] exp_q [$];
        logic [DW:0] ret;
        bit          have_ret;
        int          m_denied;
        bit          m_locked;
        bit          c_hold;
        bit          c_req, l_req, eg_c, eg_l, e_we;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_wdata;
        int          r;
        for (int a = 0; a < 4096; a++) ref_mem[a] = mem[a];
        m_denied = 0;
        m_locked = 0;
        c_hold   = 0;
        drive_idle();
        for (int cyc = 0; cyc < 500; cyc++) begin
            if (!c_hold) begin
                r = $urandom_range(0, 7);
                bus.core_rd    = (r == 1 || r == 2 || r == 3 || r == 7);
                bus.core_wr    = (r == 4 || r == 7);
                bus.core_addr  = AW'($urandom_range(0, 63));
                bus.core_wdata = DW'($urandom);
            end
            r = $urandom_range(0, 5);
            bus.ld_rd    = (r == 1 || r == 2 || r == 5);
            bus.ld_wr    = (r == 3 || r == 5);
            bus.ld_addr  = AW'($urandom_range(0, 63));
            bus.ld_wdata = DW'($urandom);
            if ($urandom_range(0, 7) == 0) bus.ld_lock = !bus.ld_lock;

            c_req = bus.core_rd || bus.core_wr;
            l_req = bus.ld_rd || bus.ld_wr;
            if (m_locked && bus.ld_lock) begin
                eg_c = 0;
                eg_l = l_req;
            end else begin
                eg_l = l_req && (!c_req || m_denied >= LIM);
                eg_c = c_req && !eg_l;
            end
            e_we    = eg_l ? bus.ld_wr : bus.core_wr;
            e_addr  = eg_l ? bus.ld_addr : bus.core_addr;
            e_wdata = eg_l ? bus.ld_wdata : bus.core_wdata;
            have_ret = (exp_q.size() > 0);
            ret      = have_ret ? exp_q.pop_front() : '0;

            @(negedge mclk);
            checks++;
            if (bus.core_gnt !== eg_c || bus.ld_gnt !== eg_l || bus.mem_en !== (eg_c || eg_l)) begin
                errors++;
                $display("FAIL rnd_grant cyc=%0d core=%b ld=%b en=%b exp=%b/%b/%b",
                         cyc, bus.core_gnt, bus.ld_gnt, bus.mem_en, eg_c, eg_l, eg_c || eg_l);
            end
            if (eg_c || eg_l) begin
                checks++;
                if (bus.mem_we !== e_we || bus.mem_addr !== e_addr || (e_we && bus.mem_wdata !== e_wdata)) begin
                    errors++;
                    $display("FAIL rnd_membus cyc=%0d we=%b addr=%h wdata=%h exp=%b/%h/%h",
                             cyc, bus.mem_we, bus.mem_addr, bus.mem_wdata, e_we, e_addr, e_wdata);
                end
            end
            checks++;
            if (bus.core_rvalid !== (have_ret && ret[DW] == OWN_CORE) ||
                bus.ld_rvalid !== (have_ret && ret[DW] == OWN_LD)) begin
                errors++;
                $display("FAIL rnd_rvalid cyc=%0d core=%b ld=%b exp_have=%b exp_own=%b",
                         cyc, bus.core_rvalid, bus.ld_rvalid, have_ret, ret[DW]);
            end
            if (have_ret) begin
                checks++;
                if ((ret[DW] == OWN_CORE ? bus.core_rdata : bus.ld_rdata) !== ret[DW-1:0]) begin
                    errors++;
                    $display("FAIL rnd_rdata cyc=%0d own=%b core=%h ld=%h exp=%h",
                             cyc, ret[DW], bus.core_rdata, bus.ld_rdata, ret[DW-1:0]);
                end
            end
            checks++;
            if (bus.locked !== m_locked || bus.dbg_wait_cnt !== 4'(m_denied)) begin
                errors++;
                $display("FAIL rnd_state cyc=%0d locked=%b wait=%0d exp=%b/%0d",
                         cyc, bus.locked, bus.dbg_wait_cnt, m_locked, m_denied);
            end

            if (eg_c || eg_l) begin
                if (e_we) ref_mem[e_addr] = e_wdata;
                else      exp_q.push_back({eg_l ? OWN_LD : OWN_CORE, ref_mem[e_addr]});
            end
            m_denied = (l_req && !eg_l) ? ((m_denied < LIM) ? m_denied + 1 : LIM) : 0;
            m_locked = m_locked ? bus.ld_lock : (eg_l && bus.ld_lock);
            c_hold   = c_req && !eg_c;
            tick();
        end
        drive_idle();
        tick();
        tick();
    endtask

    initial begin
        bus.mem_rdata = '0;
        for (int a = 0; a < 4096; a++) mem[a] = DW'($urandom);
        test_reset();
        test_core_read();
        test_contention();
        test_lock_burst();
        test_interleaved();
        test_rd_wr_both();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
